// File: rtl/mux8_sched_pkg.sv
// Shared constants and FSM state encoding for the 8-lane round-robin scheduler.
package mux8_sched_pkg;
  localparam int NUM_LANES = 8;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] PTR_RST = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping mod 8.
module rr_pick8
  import mux8_sched_pkg::*;
(
  input  logic [NUM_LANES-1:0] req,
  input  logic [SEL_W-1:0]     ptr,
  output logic                 any,
  output logic [SEL_W-1:0]     idx,
  output logic [NUM_LANES-1:0] onehot
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    any    = 1'b0;
    idx    = '0;
    cand   = '0;
    onehot = '0;
    // Offset 8 wraps back onto ptr itself, so that lane is searched last.
    for (int k = 1; k <= NUM_LANES; k++) begin
      cand = ptr + SEL_W'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// 8:1 round-robin scheduler with a one-entry registered output and ready/valid handshake.
module mux8_rr_scheduler
  import mux8_sched_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_LANES-1:0]       req,
  input  logic [NUM_LANES*WIDTH-1:0] data_in,
  output logic [NUM_LANES-1:0]       grant,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [SEL_W-1:0]           out_sel
);

  state_t           state, state_d;
  logic [SEL_W-1:0] ptr;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic [NUM_LANES-1:0] pick_onehot;
  logic             capture;
  logic [WIDTH-1:0] lane_data;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign lane_data = data_in[pick_idx*WIDTH +: WIDTH];

  // The output slot is free when empty or being drained this edge; reset masks grant.
  assign capture = rst && pick_any && ((state == IDLE) || out_ready);
  assign grant   = capture ? pick_onehot : '0;
  assign out_valid = (state == BUSY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (capture)                          state_d = BUSY;
    else if ((state == BUSY) && out_ready) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= PTR_RST;
      out_data <= '0;
      out_sel  <= '0;
    end else if (capture) begin
      ptr      <= pick_idx;
      out_data <= lane_data;
      out_sel  <= pick_idx;
    end
  end

endmodule
